// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // RISC-V funct3 encodings for loads/stores (stores use the low two bits only).
  localparam logic [2:0] F3_B    = 3'b000;
  localparam logic [2:0] F3_H    = 3'b001;
  localparam logic [2:0] F3_W    = 3'b010;
  localparam logic [2:0] F3_D    = 3'b011;
  localparam logic [2:0] F3_BU   = 3'b100;
  localparam logic [2:0] F3_HU   = 3'b101;
  localparam logic [2:0] F3_WU   = 3'b110;
  localparam logic [2:0] F3_RSVD = 3'b111;

  // Access size encodings, identical to the memory's word port.
  localparam logic [1:0] SZ_BYTE   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_WORD   = 2'b10;
  localparam logic [1:0] SZ_DOUBLE = 2'b11;

  localparam int unsigned MEM_AW = 12;

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = |addr_lo[1:0];
      default: mis = |addr_lo[2:0];
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extension: selects the low byte/half/word/double of the raw
// memory value and sign- or zero-extends it according to funct3.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [63:0] raw_i,
  output logic [63:0] rdata_o
);

  // Extend the raw little-endian value to 64 bits.
  always_comb begin
    // NOTE: default assigned first so every path drives rdata_o and no latch is inferred.
    rdata_o = raw_i;
    case (funct3_i)
      F3_B:    rdata_o = {{56{raw_i[7]}},  raw_i[7:0]};
      F3_H:    rdata_o = {{48{raw_i[15]}}, raw_i[15:0]};
      F3_W:    rdata_o = {{32{raw_i[31]}}, raw_i[31:0]};
      F3_D:    rdata_o = raw_i;
      F3_BU:   rdata_o = {56'd0, raw_i[7:0]};
      F3_HU:   rdata_o = {48'd0, raw_i[15:0]};
      F3_WU:   rdata_o = {32'd0, raw_i[31:0]};
      default: rdata_o = raw_i; // reserved encoding faults before any access
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV64 load/store unit: accepts one request in IDLE, checks it, drives the
// data memory for a single ACCESS cycle and holds the response in RESP until
// writeback takes it.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic [4:0]  rsp_rd,
  output logic        rsp_fault,
  output logic [11:0] mem_addr,
  output logic [63:0] mem_dataw,
  output logic [1:0]  mem_word,
  output logic        mem_rw,
  input  logic [63:0] mem_datar
);

  state_e      state_q, state_d;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [11:0] addr_q;
  logic [63:0] wdata_q;
  logic [4:0]  rd_q;
  logic        fault_q;
  logic [63:0] rdata_q;

  logic        accept;
  logic        req_fault;
  logic [63:0] ext_rdata;

  assign accept = (state_q == ST_IDLE) && req_valid;

  // Classify the incoming request: out of range, misaligned or illegal funct3.
  always_comb begin
    req_fault = (req_addr[63:MEM_AW] != '0)
             || is_misaligned(req_funct3[1:0], req_addr[2:0])
             || (!req_store && (req_funct3 == F3_RSVD))
             || (req_store && req_funct3[2]);
  end

  // Next-state logic: faults skip ACCESS and go straight to RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = req_fault ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Request capture on accept; load data captured at the end of ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these registers drive outputs directly, so they are reset to give defined values.
    if (rst) begin
      store_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      fault_q  <= 1'b0;
      rdata_q  <= '0;
    end else if (accept) begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      store_q  <= req_store;
      funct3_q <= req_funct3;
      addr_q   <= req_addr[MEM_AW-1:0];
      wdata_q  <= req_wdata;
      rd_q     <= req_rd;
      fault_q  <= req_fault;
      rdata_q  <= '0;
    end else if ((state_q == ST_ACCESS) && !store_q) begin
      rdata_q  <= ext_rdata;
    end
  end

  lsu_load_ext u_load_ext (
    .funct3_i (funct3_q),
    .raw_i    (mem_datar),
    .rdata_o  (ext_rdata)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_rd    = rd_q;
  assign rsp_fault = fault_q;
  assign mem_addr  = addr_q;
  assign mem_dataw = wdata_q;
  assign mem_word  = funct3_q[1:0];
  // Write strobe decoded from state so an asynchronous reset drops it at once.
  assign mem_rw    = (state_q == ST_ACCESS) && store_q && !fault_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a byte-array memory model serves the DUT, a
// separate reference memory plus arithmetic model predicts each response.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic [4:0]  rsp_rd;
  logic        rsp_fault;
  logic [11:0] mem_addr;
  logic [63:0] mem_dataw;
  logic [1:0]  mem_word;
  logic        mem_rw;
  logic [63:0] mem_datar;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_rd     (rsp_rd),
    .rsp_fault  (rsp_fault),
    .mem_addr   (mem_addr),
    .mem_dataw  (mem_dataw),
    .mem_word   (mem_word),
    .mem_rw     (mem_rw),
    .mem_datar  (mem_datar)
  );

  // ---------------- environment memory (driven by the DUT) ----------------
  logic [7:0] dut_mem [4096];

  always @(posedge clk) begin
    if (mem_rw)
      for (int i = 0; i < (1 << mem_word); i++)
        dut_mem[(int'(mem_addr) + i) % 4096] <= mem_dataw[8*i +: 8];
  end

  always_comb begin
    mem_datar = '0;
    for (int i = 0; i < 8; i++)
      mem_datar[8*i +: 8] = dut_mem[(int'(mem_addr) + i) % 4096];
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [4096];

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        fault;
    int          lat;
    int          writes;
    int          accept_cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Spec-level prediction of one request; stores update the reference memory.
  function automatic exp_t model(input logic st, input logic [2:0] f3,
                                 input logic [63:0] a, input logic [63:0] wd,
                                 input logic [4:0] rd);
    exp_t        e;
    int          n;
    logic [63:0] v;
    logic [63:0] ones;
    n    = 1 << f3[1:0];
    v    = '0;
    ones = '1;
    e.rd = rd;
    e.fault = (a >= 64'd4096) || ((a % 64'(n)) != 0)
           || (!st && f3 == 3'b111) || (st && f3[2]);
    e.rdata  = '0;
    e.writes = 0;
    e.lat    = e.fault ? 1 : 2;
    e.accept_cyc = 0;
    if (!e.fault) begin
      if (st) begin
        for (int i = 0; i < n; i++) ref_mem[(int'(a[11:0]) + i) % 4096] = wd[8*i +: 8];
        e.writes = 1;
      end else begin
        for (int i = 0; i < n; i++)
          v = v | (64'(ref_mem[(int'(a[11:0]) + i) % 4096]) << (8*i));
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | (ones << (8*n));
        e.rdata = v;
      end
    end
    return e;
  endfunction

  // ---------------- response ready generation ----------------
  logic rand_ready_en = 1'b1;
  logic man_ready     = 1'b0;
  logic rnd_ready     = 1'b1;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 3) != 0);
  end

  assign rsp_ready = rand_ready_en ? rnd_ready : man_ready;

  // ---------------- monitor ----------------
  logic        in_rsp = 1'b0;
  int          first_cyc;
  int          wr_cnt = 0;
  logic [63:0] prev_rdata;
  logic [4:0]  prev_rd;
  logic        prev_fault;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      in_rsp = 1'b0;
      wr_cnt = 0;
    end else begin
      if (mem_rw) wr_cnt++;
      if (rsp_valid) begin
        check("req_ready_low_in_rsp", req_ready, 1'b0);
        if (in_rsp) begin
          check("stable_rdata", rsp_rdata, prev_rdata);
          check("stable_rd",    rsp_rd,    prev_rd);
          check("stable_fault", rsp_fault, prev_fault);
        end else begin
          first_cyc = cyc;
        end
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            fail_now("unexpected_response");
          end else begin
            e = sb.pop_front();
            check("rsp_rdata",  rsp_rdata, e.rdata);
            check("rsp_rd",     rsp_rd,    e.rd);
            check("rsp_fault",  rsp_fault, e.fault);
            check("latency",    first_cyc - e.accept_cyc, e.lat);
            check("write_cycles", wr_cnt, e.writes);
          end
          in_rsp = 1'b0;
          wr_cnt = 0;
        end else begin
          in_rsp     = 1'b1;
          prev_rdata = rsp_rdata;
          prev_rd    = rsp_rd;
          prev_fault = rsp_fault;
        end
      end
    end
  end

  // ---------------- driver helpers (called at posedge+1) ----------------
  task automatic wait_ready();
    int g = 0;
    while (!req_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!req_ready) fail_now("req_ready_timeout");
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input logic [4:0] rd,
                       input logic use_exp, input logic [63:0] exp_rdata,
                       input logic exp_fault);
    exp_t e;
    wait_ready();
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_rd     = rd;
    e = model(st, f3, a, wd, rd);
    if (use_exp) begin
      e.rdata = exp_rdata;
      e.fault = exp_fault;
    end
    e.accept_cyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((sb.size() != 0 || !req_ready) && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int g;
    int diffs;
    logic [7:0] b;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_rd     = '0;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      dut_mem[i] <= b;
      ref_mem[i] = b;
    end
    #1;
    check("reset_req_ready", req_ready, 1'b1);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_rdata", rsp_rdata, 64'd0);
    check("reset_rsp_rd",    rsp_rd,    5'd0);
    check("reset_rsp_fault", rsp_fault, 1'b0);
    check("reset_mem_addr",  mem_addr,  12'd0);
    check("reset_mem_dataw", mem_dataw, 64'd0);
    check("reset_mem_word",  mem_word,  2'd0);
    check("reset_mem_rw",    mem_rw,    1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed test-plan requests with expected data written out explicitly.
    issue(1'b1, 3'b011, 64'h010, 64'h8877665544332211, 5'd1, 1'b1, 64'd0, 1'b0);
    issue(1'b0, 3'b011, 64'h010, 64'd0, 5'd2, 1'b1, 64'h8877665544332211, 1'b0);
    issue(1'b1, 3'b000, 64'h020, 64'h00000000000000FF, 5'd3, 1'b1, 64'd0, 1'b0);
    issue(1'b0, 3'b000, 64'h020, 64'd0, 5'd4, 1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    issue(1'b0, 3'b100, 64'h020, 64'd0, 5'd5, 1'b1, 64'h00000000000000FF, 1'b0);
    issue(1'b1, 3'b010, 64'h030, 64'h0000000080000001, 5'd6, 1'b1, 64'd0, 1'b0);
    issue(1'b0, 3'b010, 64'h030, 64'd0, 5'd7, 1'b1, 64'hFFFFFFFF80000001, 1'b0);
    issue(1'b0, 3'b110, 64'h030, 64'd0, 5'd8, 1'b1, 64'h0000000080000001, 1'b0);
    issue(1'b0, 3'b001, 64'h030, 64'd0, 5'd9, 1'b1, 64'h0000000000000001, 1'b0);
    issue(1'b0, 3'b010, 64'h032, 64'd0, 5'd10, 1'b1, 64'd0, 1'b1);
    issue(1'b1, 3'b011, 64'h1000, 64'hDEADBEEFDEADBEEF, 5'd11, 1'b1, 64'd0, 1'b1);
    issue(1'b0, 3'b111, 64'h008, 64'd0, 5'd12, 1'b1, 64'd0, 1'b1);
    issue(1'b1, 3'b100, 64'h040, 64'd0, 5'd13, 1'b1, 64'd0, 1'b1);
    issue(1'b0, 3'b101, 64'h031, 64'd0, 5'd14, 1'b1, 64'd0, 1'b1);
    wait_drain();

    // Backpressure: hold rsp_ready low for 5 cycles after an LD.
    rand_ready_en = 1'b0;
    man_ready     = 1'b0;
    issue(1'b0, 3'b011, 64'h010, 64'd0, 5'd21, 1'b1, 64'h8877665544332211, 1'b0);
    g = 0;
    while (!rsp_valid && g < 10) begin
      @(posedge clk); #1;
      g++;
    end
    if (!rsp_valid) fail_now("bp_rsp_valid_timeout");
    repeat (5) begin
      check("bp_req_ready", req_ready, 1'b0);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      @(posedge clk); #1;
    end
    man_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", rsp_valid, 1'b0);
    check("bp_release_ready", req_ready, 1'b1);
    check("bp_popped", 64'(sb.size()), 64'd0);
    man_ready     = 1'b0;
    rand_ready_en = 1'b1;
    wait_drain();

    // Reset in the middle of an SD access: the write must not happen.
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b011;
    req_addr   = 64'h040;
    req_wdata  = 64'hA5A5A5A5A5A5A5A5;
    req_rd     = 5'd30;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_access_mem_rw", mem_rw, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_mem_rw",    mem_rw,    1'b0);
    check("rst_mid_req_ready", req_ready, 1'b1);
    check("rst_mid_rsp_valid", rsp_valid, 1'b0);
    check("rst_mid_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_mid_rsp_rd",    rsp_rd,    5'd0);
    check("rst_mid_rsp_fault", rsp_fault, 1'b0);
    check("rst_mid_mem_addr",  mem_addr,  12'd0);
    check("rst_mid_mem_dataw", mem_dataw, 64'd0);
    check("rst_mid_mem_word",  mem_word,  2'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) check("rst_mem_unchanged", dut_mem[16'h40 + i], ref_mem[16'h40 + i]);
    @(posedge clk); #1;
    issue(1'b0, 3'b011, 64'h040, 64'd0, 5'd31, 1'b0, 64'd0, 1'b0);
    wait_drain();

    // Randomised mix of loads, stores and faulting requests.
    for (int k = 0; k < 300; k++) begin
      logic [63:0] a;
      a = 64'h100 + 64'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) a = a | (64'd1 << (12 + $urandom_range(0, 51)));
      issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
            {$urandom, $urandom}, 5'($urandom), 1'b0, 64'd0, 1'b0);
    end
    wait_drain();

    diffs = 0;
    for (int i = 0; i < 4096; i++) if (dut_mem[i] !== ref_mem[i]) diffs++;
    check("final_memory_image", 64'(diffs), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that sits between the execute stage and the byte-addressed data memory, acting as the initiator of memory transactions. It accepts one RISC-V RV64 load or store per handshake from the pipeline and checks alignment and range. It drives the memory's addr/dataw/word/rw port for exactly one access cycle, then returns sign/zero-extended load data or a store completion to writeback over a ready/valid response channel.

## Interface
- No parameters; the memory is fixed at 4096 bytes (12-bit address).
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (LB/LH/LW/LD/LBU/LHU/LWU; SB/SH/SW/SD)
- req_addr  in  64  effective byte address
- req_wdata  in  64  store data, low bytes significant
- req_rd  in  5  destination register tag, echoed in response
- rsp_valid  out  1  response pending
- rsp_ready  in  1  writeback accepts response
- rsp_rdata  out  64  extended load data; 0 for stores and faults
- rsp_rd  out  5  echoed tag
- rsp_fault  out  1  misaligned, out-of-range or illegal funct3
- mem_addr  out  12  byte address to data memory
- mem_dataw  out  64  store data to memory
- mem_word  out  2  size: 00 byte, 01 half, 10 word, 11 double
- mem_rw  out  1  write strobe; memory writes on posedge while high
- mem_datar  in  64  combinational read data: little-endian 8 bytes starting at mem_addr

## Operation
- States: IDLE, ACCESS, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid, capture all req_* fields. A fault goes to RESP with rsp_fault=1; otherwise the unit goes to ACCESS.
- Fault conditions:
  - req_addr[63:12] ≠ 0.
  - Address not aligned to size (half: addr[0]; word: addr[1:0]; double: addr[2:0]).
  - Load with funct3=111.
  - Store with funct3[2]=1.
- ACCESS (exactly one cycle): mem_addr=addr[11:0], mem_word=funct3[1:0], mem_dataw=wdata. For stores, mem_rw=1. For loads, mem_rw=0 and mem_datar is sampled at the closing edge. Then go to RESP.
- Load extension from the sampled 64-bit value:
  - funct3[2]=0 sign-extends bit 7/15/31 of the low byte/half/word.
  - funct3[2]=1 zero-extends.
  - LD passes all 64 bits.
- RESP: rsp_valid=1; rsp_* are stable until the cycle rsp_ready=1, then IDLE. The next request is accepted no earlier than the following cycle, so there is no back-to-back overlap.
- mem_rw=1 only in ACCESS with a non-faulting store. It is decoded from the state register, so it drops asynchronously with rst.
- Faulting requests never assert mem_rw and never enter ACCESS.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_rd=0, rsp_fault=0, mem_addr=0, mem_dataw=0, mem_word=0, mem_rw=0.
- Request accepted at edge E0:
  - ACCESS spans E0→E1.
  - rsp_valid is high from E1.
  - Minimum request-to-response latency is 1 cycle for faults and 2 cycles for accesses.
- Throughput: at most one request per 3 cycles with rsp_ready tied high.
- rsp_ready high while rsp_valid=0 is ignored.
- Reset mid-ACCESS: the store is dropped (no write edge occurs with mem_rw=1), the response is lost, and the unit returns to IDLE.

## Structure
- Package lsu_pkg:
  - State enum.
  - funct3 constants (F3_B=000, F3_H=001, F3_W=010, F3_D=011, F3_BU=100, F3_HU=101, F3_WU=110).
  - Size encodings matching mem_word.
- Sub-module lsu_load_ext: combinational extension, (funct3, raw64) → rdata64.
- Top lsu: FSM, request capture registers, fault check, memory drive.

## Test plan
- SD addr=0x010 data=0x8877665544332211, then LD 0x010 → rsp_rdata=0x8877665544332211, rsp_fault=0; mem_rw high exactly one cycle.
- SB 0x020 data=0xFF, then LB 0x020 → 0xFFFFFFFFFFFFFFFF; LBU 0x020 → 0x00000000000000FF.
- SW 0x030 data=0x80000001, then LW → 0xFFFFFFFF80000001; LWU → 0x0000000080000001; LH 0x030 → 0x0000000000000001.
- Faults:
  - LW addr=0x032 → rsp_fault=1, rsp_rdata=0.
  - SD addr=0x1000 → rsp_fault=1, mem_rw never asserted.
  - Load funct3=111 → rsp_fault=1.
  - Each fault response arrives 1 cycle after accept.
- Backpressure: hold rsp_ready=0 for 5 cycles after an LD → rsp_valid/rsp_rdata/rsp_rd stable and req_ready=0 throughout; accepted on the cycle rsp_ready rises.
- Assert rst during ACCESS of SD 0x040 → mem_rw falls immediately, memory at 0x040 unchanged, all outputs at reset values, next LD 0x040 returns the prior contents.
